perf_counter_unit: RTL
======================

Name: perf_counter_unit

Overview:
- Producer side of the CPU performance-statistics path.
- Lives inside the datapath and accumulates the stall, arithmetic and memory event counts.
- At program end, computes integer cycles-per-instruction with an iterative divider.
- Its registered outputs are the values presented on R28..R31 to the in-system probe logic.

Parameters:
- CNT_W, 19: width of every counter and of the CPI result.

Ports:
- clkFPGA  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserts immediately, released synchronously by the caller).
- clear  input  1  synchronous clear of all counters and return to counting.
- enable  input  1  counting qualifier; events and cycles are ignored when low.
- finish_i  input  1  program-end indication from the datapath.
- stall_i  input  1  pipeline stalled this cycle.
- arith_retire_i  input  1  arithmetic instruction retired this cycle.
- mem_retire_i  input  1  memory instruction retired this cycle.
- inst_retire_i  input  1  any instruction retired this cycle.
- stall_count  output  CNT_W  R28 value.
- arith_count  output  CNT_W  R29 value.
- mem_count  output  CNT_W  R30 value.
- cpi  output  CNT_W  R31 value: floor(cycle_count / inst_count).
- cycle_count  output  CNT_W  active cycles counted.
- cpi_valid  output  1  cpi holds a final result.
- busy  output  1  divider running.

Behaviour:
- Reset (rst low): all counts, internal inst_count, cpi, cpi_valid and busy = 0; FSM = COUNT.
- FSM states:
  - COUNT: each edge with enable=1, cycle_count +1; each other counter +1 when its event input is 1.
  - Every counter saturates at 2^CNT_W-1 and never wraps.
  - finish_i=1 in COUNT: that cycle's events are still counted, then go to DIVIDE. If enable=0 that cycle, no events are counted but the transition still happens.
  - DIVIDE: restoring shift-subtract, one quotient bit per cycle, CNT_W cycles; busy=1. Dividend = frozen cycle_count, divisor = frozen inst_count. All counters frozen.
  - After the last iteration: cpi <= quotient, cpi_valid <= 1, go to DONE.
  - Zero divisor: on entry, go straight to DONE; cpi = 2^CNT_W-1, cpi_valid=1 one edge after the finish edge.
  - DONE: all outputs held; finish_i and event inputs ignored.
- Latency: finish sampled at edge t; busy high edges t+1..t+CNT_W; cpi_valid=1 from edge t+CNT_W+1.
- clear=1 in any state (including mid-DIVIDE): next edge zeroes every counter, cpi and cpi_valid; busy=0; state = COUNT. clear has priority over finish_i and all events in the same cycle.
- Outputs are registered; count values are visible live during COUNT.
- Quotient is truncated, no rounding. Since cycle_count is ≥ inst_count in valid operation, cpi ≥ 1.

Decomposition:
- Shared package perf_pkg:
  - state enum {COUNT, DIVIDE, DONE}
  - CNT_W default constant
  - CNT_MAX constant
- One sub-module is natural: seq_divider, an iterative unsigned divider with start/busy/done, parameterised by width, with its own zero-divisor flag.
- Counters stay inline, using a saturating-increment function in perf_pkg.

Test Plan:
- Reset then 10 enabled cycles with inst_retire_i every other cycle, then finish → cycle_count=11 (includes the finish cycle), cpi=floor(11/5)=2; cpi_valid rises exactly 20 edges after the finish edge.
- stall_i, arith_retire_i and mem_retire_i held high for 7 enabled cycles, plus 3 cycles with enable=0 → stall=arith=mem=7, cycle_count=7.
- Force counters near max: 524290 enabled cycles with stall_i high → stall_count=524287 and holds, no wrap.
- finish with inst_count=0 → cpi=524287, cpi_valid=1 one edge after finish, busy never high.
- clear asserted at DIVIDE iteration 5 → next edge all outputs 0, busy=0, counting resumes; same-cycle clear+finish → stays in COUNT with zeros.
- rst pulled low mid-DIVIDE, asynchronously between edges → outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/perf_counter_unit_pkg.sv
// Shared state type, width constants and the saturating-increment helper
// used by the performance counter unit.
package perf_pkg;

   typedef enum logic [1:0] {
      COUNT  = 2'd0,
      DIVIDE = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int CNT_W_DEFAULT = 19;
   localparam logic [CNT_W_DEFAULT-1:0] CNT_MAX = '1;

   // Counter slots held in the unit's counter array.
   localparam int NUM_CNT   = 5;
   localparam int IDX_CYCLE = 0;
   localparam int IDX_STALL = 1;
   localparam int IDX_ARITH = 2;
   localparam int IDX_MEM   = 3;
   localparam int IDX_INST  = 4;

   // Widths up to 32 bits share one helper; callers cast back to their width.
   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input logic [31:0] max_value,
                                           input logic        inc);
      if (inc && (value != max_value)) begin
         return value + 32'd1;
      end
      return value;
   endfunction

endpackage

// File: rtl/perf_counter_unit_if.sv
// Event inputs and statistics outputs of the performance counter unit.
interface perf_counter_unit_if #(
   parameter int CNT_W = perf_pkg::CNT_W_DEFAULT
);
   logic             clear;
   logic             enable;
   logic             finish_i;
   logic             stall_i;
   logic             arith_retire_i;
   logic             mem_retire_i;
   logic             inst_retire_i;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] arith_count;
   logic [CNT_W-1:0] mem_count;
   logic [CNT_W-1:0] cpi;
   logic [CNT_W-1:0] cycle_count;
   logic             cpi_valid;
   logic             busy;

   modport master (
      output clear, enable, finish_i, stall_i, arith_retire_i, mem_retire_i, inst_retire_i,
      input  stall_count, arith_count, mem_count, cpi, cycle_count, cpi_valid, busy
   );

   modport slave (
      input  clear, enable, finish_i, stall_i, arith_retire_i, mem_retire_i, inst_retire_i,
      output stall_count, arith_count, mem_count, cpi, cycle_count, cpi_valid, busy
   );
endinterface

// File: rtl/perf_counter_unit_seq_divider.sv
// Iterative restoring unsigned divider: one quotient bit per clock, W clocks.
// A zero divisor is flagged at start and never launches an iteration.
module seq_divider #(
   parameter int W = 19
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_start,
   input  logic         i_abort,
   input  logic [W-1:0] i_dividend,
   input  logic [W-1:0] i_divisor,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_div_zero,
   output logic [W-1:0] o_quotient
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic [W-1:0]  r_rem;
   logic [W-1:0]  r_quo;
   logic [W-1:0]  r_divisor;
   logic [CW-1:0] r_cnt;
   logic          r_busy;

   logic [W:0]    w_shift;
   logic [W-1:0]  w_diff;
   logic          w_fits;
   logic [W-1:0]  w_rem_next;
   logic [W-1:0]  w_quo_next;

   // Dividend bits shift out of r_quo's MSB while quotient bits shift in at the LSB.
   always_comb begin
      w_shift    = {r_rem, r_quo[W-1]};
      w_fits     = (w_shift >= {1'b0, r_divisor});
      w_diff     = w_shift[W-1:0] - r_divisor;
      w_rem_next = w_fits ? w_diff : w_shift[W-1:0];
      w_quo_next = {r_quo[W-2:0], w_fits};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem     <= '0;
         r_quo     <= '0;
         r_divisor <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
      end else if (i_abort) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (r_busy) begin
         r_rem <= w_rem_next;
         r_quo <= w_quo_next;
         r_cnt <= r_cnt + CW'(1);
         if (r_cnt == LAST) begin
            r_busy <= 1'b0;
         end
      end else if (i_start && (i_divisor != '0)) begin
         r_rem     <= '0;
         r_quo     <= i_dividend;
         r_divisor <= i_divisor;
         r_cnt     <= '0;
         r_busy    <= 1'b1;
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_busy && (r_cnt == LAST) && !i_abort;
   assign o_div_zero = i_start && (i_divisor == '0);
   assign o_quotient = w_quo_next;

endmodule

// File: rtl/perf_counter_unit.sv
// Saturating stall/arith/mem/cycle/instruction counters; at program end the
// unit divides cycles by instructions and holds the CPI for the probe logic.
module perf_counter_unit
   import perf_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input logic              clkFPGA,
   input logic              rst,
   perf_counter_unit_if.slave bus
);
   localparam logic [CNT_W-1:0] W_MAX = '1;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt [NUM_CNT];
   logic [CNT_W-1:0] r_cpi;
   logic             r_cpi_valid;

   logic [CNT_W-1:0] w_cnt_next [NUM_CNT];
   logic [NUM_CNT-1:0] w_event;
   logic             w_start;
   logic             w_div_busy;
   logic             w_div_done;
   logic             w_div_zero;
   logic [CNT_W-1:0] w_quotient;

   assign w_event[IDX_CYCLE] = 1'b1;
   assign w_event[IDX_STALL] = bus.stall_i;
   assign w_event[IDX_ARITH] = bus.arith_retire_i;
   assign w_event[IDX_MEM]   = bus.mem_retire_i;
   assign w_event[IDX_INST]  = bus.inst_retire_i;

   generate
      for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
         assign w_cnt_next[gi] = CNT_W'(sat_inc(32'(r_cnt[gi]), 32'(W_MAX),
                                                bus.enable & w_event[gi]));
      end
   endgenerate

   // The divider sees the counts including the finish cycle's own events.
   assign w_start = (r_state == COUNT) && bus.finish_i && !bus.clear;

   seq_divider #(.W(CNT_W)) u_div (
      .clk        (clkFPGA),
      .rst_n      (rst),
      .i_start    (w_start),
      .i_abort    (bus.clear),
      .i_dividend (w_cnt_next[IDX_CYCLE]),
      .i_divisor  (w_cnt_next[IDX_INST]),
      .o_busy     (w_div_busy),
      .o_done     (w_div_done),
      .o_div_zero (w_div_zero),
      .o_quotient (w_quotient)
   );

   always_ff @(posedge clkFPGA or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            r_cnt[i] <= '0;
         end
         r_cpi       <= '0;
         r_cpi_valid <= 1'b0;
         r_state     <= COUNT;
      end else if (bus.clear) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            r_cnt[i] <= '0;
         end
         r_cpi       <= '0;
         r_cpi_valid <= 1'b0;
         r_state     <= COUNT;
      end else begin
         case (r_state)
            COUNT: begin
               for (int i = 0; i < NUM_CNT; i++) begin
                  r_cnt[i] <= w_cnt_next[i];
               end
               if (bus.finish_i) begin
                  if (w_div_zero) begin
                     r_cpi       <= W_MAX;
                     r_cpi_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_state <= DIVIDE;
                  end
               end
            end
            DIVIDE: begin
               if (w_div_done) begin
                  r_cpi       <= w_quotient;
                  r_cpi_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               r_state <= DONE;
            end
            default: r_state <= COUNT;
         endcase
      end
   end

   assign bus.stall_count = r_cnt[IDX_STALL];
   assign bus.arith_count = r_cnt[IDX_ARITH];
   assign bus.mem_count   = r_cnt[IDX_MEM];
   assign bus.cycle_count = r_cnt[IDX_CYCLE];
   assign bus.cpi         = r_cpi;
   assign bus.cpi_valid   = r_cpi_valid;
   assign bus.busy        = w_div_busy;

endmodule
